cdc_tx_3g2g: RTL and testbench
==============================

# cdc_tx_3g2g

Transmit-side gearbox for the fixed 3:2 rational crossing from the clk_3g domain into the clk_2g domain. Accepts a valid/ready word stream in clk_3g and launches each word into a launch register at exactly two fixed phases of the 3-cycle frame. The clk_2g receiver captures slot A on its mid-frame edge and slot B on its frame-boundary edge, so every sampled word is stable with at least half a clk_3g period of margin. A small FIFO absorbs bursts, because the crossing drains at most 2 words per 3 clk_3g cycles.

## Interface
- DATA_W, default 8, payload width.
- FIFO_DEPTH, default 4, input buffer depth in words; power of 2, at least 2.
- clk_3g  in  1  sole clock; frame boundary is phase-aligned with clk_2g rising edges.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  producer word valid.
- in_data  in  DATA_W  producer word.
- in_ready  out  1  FIFO can accept a word.
- tx_data  out  DATA_W  launch register, driven into the clk_2g domain.
- tx_valid  out  1  tx_data holds a new word for this slot.
- tx_tag  out  1  toggles once per launched valid word.
- phase  out  2  frame phase counter, value 0, 1, 2.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy.

## Operation
- Frame counter
  - phase counts 0→1→2→0.
  - Cycle n after rst deasserts has phase n mod 3.
- Input side
  - in_ready = (fifo_count != FIFO_DEPTH). It is derived from registered count only; there is no combinational path from pop.
  - A push occurs on any edge where in_valid && in_ready. in_data is written at the tail.
- Launch edges: only two edges per frame.
  - Edge A is the edge where phase goes 0→1. The launched word occupies phase 1 and is sampled by the mid-frame clk_2g edge.
  - Edge B is the edge where phase goes 1→2. The launched word is held through phase 2 and the next phase 0, and is sampled by the frame-boundary clk_2g edge.
  - The 2→0 edge never changes tx_data, tx_valid or tx_tag.
- Pop at a launch edge
  - The pop decision uses the pre-edge fifo_count.
  - If the FIFO is non-empty: pop the head, load it into tx_data, set tx_valid=1, invert tx_tag.
  - If the FIFO is empty: tx_valid=0, and tx_data and tx_tag hold their values.
- Push and pop on the same edge
  - Both take effect; fifo_count is unchanged.
  - A word pushed into an empty FIFO on a launch edge is not popped on that edge. It leaves at the next launch edge.
- FIFO behaviour
  - Order is FIFO.
  - Pointers wrap modulo FIFO_DEPTH.
  - A full FIFO never accepts a word. An empty FIFO never pops.
- Reset
  - rst asserted at any cycle, including mid-frame or with data buffered, flushes the FIFO.
  - No partial word is ever launched after a reset.

## Timing
- Reset values (cycle after the rst edge)
  - phase=0, fifo_count=0, in_ready=1.
  - tx_data=0, tx_valid=0, tx_tag=0.
- Throughput
  - Output: 2 words per 3 cycles maximum.
  - Input: 1 word per cycle while not full.
- Accept-to-launch latency with the FIFO empty, measured from the accepting edge to the first cycle tx_valid=1 with the word:
  - Word accepted on the edge ending phase 0: 2 cycles; appears in phase 2.
  - Word accepted on the edge ending phase 1: 3 cycles; appears in phase 1 of the next frame.
  - Word accepted on the edge ending phase 2: 2 cycles; appears in phase 1.
- Hold intervals
  - A slot A word is stable for exactly 1 cycle (phase 1).
  - A slot B word is stable for exactly 2 cycles (phase 2 and the following phase 0).

## Test plan
- Reset check: hold rst for 3 cycles, then release.
  - Required: all outputs at reset values, phase sequence 0,1,2,0,1,…, tx_valid=0 with no input.
- Single word latency: in cycle 0, push 0xA5, then in_valid=0.
  - Required: tx_valid=1 and tx_data=0xA5 in cycles 2 and 3, tx_tag=1.
  - Required: tx_valid=0 in cycle 4 and after; tx_data stays 0xA5 in cycle 4.
- Full-rate burst: FIFO_DEPTH=4, push 0x00,0x01,… every cycle from cycle 0.
  - Required: in_ready first drops in cycle 9, then stays low in 1 of every 3 cycles.
  - Required: launched data is strictly increasing with no gaps.
  - Required: tx_tag toggles on every launch edge from edge B of frame 0 onward.
- Push on launch edge into empty FIFO: push 0x3C in cycle 3 only.
  - Required: fifo_count=1 in cycle 4 (cycle 4 is phase 1, so edge A at the end of cycle 3 does not pop it).
  - Required: launched at edge B, so tx_data=0x3C valid in cycles 5 and 6.
- Mid-operation reset: fill the FIFO with 4 words, assert rst in a phase 1 cycle.
  - Required: next cycle fifo_count=0, tx_valid=0, tx_data=0, phase=0.
  - Required: none of the 4 words ever appears on tx_data.
- Wrap-around: stream 20 words with in_valid toggling pseudo-randomly.
  - Required: the output order matches the input order exactly across multiple pointer wraps.
  - Required: the tx_tag toggle count equals 20.

Source files
------------

// File: rtl/cdc_tx_3g2g.sv
// Transmit gearbox for the 3:2 clk_3g -> clk_2g crossing: buffers a valid/ready
// stream and launches words only on the two fixed slot edges of each 3-cycle frame.
module cdc_tx_3g2g #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk_3g,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          in_ready,
    output logic [DATA_W-1:0]             tx_data,
    output logic                          tx_valid,
    output logic                          tx_tag,
    output logic [1:0]                    phase,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2
    } phase_e;

    phase_e              phase_q, phase_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                ready_q, ready_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                tx_valid_q, tx_valid_d;
    logic                tx_tag_q, tx_tag_d;
    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];

    logic                push_c;
    logic                pop_c;
    logic                launch_c;

    always_ff @(posedge clk_3g) begin
        if (rst) begin
            phase_q    <= PH0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_q    <= 1'b1;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_tag_q   <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            tx_tag_q   <= tx_tag_d;
        end
    end

    // Storage needs no reset: a flush only rewinds the pointers.
    always_ff @(posedge clk_3g) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    always_comb begin
        phase_d    = phase_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        tx_tag_d   = tx_tag_q;
        launch_c   = 1'b0;

        // Edges leaving phase 0 (slot A) and phase 1 (slot B) are the only launch edges.
        case (phase_q)
            PH0: begin
                phase_d  = PH1;
                launch_c = 1'b1;
            end
            PH1: begin
                phase_d  = PH2;
                launch_c = 1'b1;
            end
            default: begin
                phase_d = PH0;
            end
        endcase

        push_c = in_valid && ready_q;
        pop_c  = launch_c && (count_q != '0);

        if (pop_c) begin
            tx_data_d  = mem_q[rd_ptr_q];
            tx_valid_d = 1'b1;
            tx_tag_d   = ~tx_tag_q;
            rd_ptr_d   = rd_ptr_q + AW'(1);
        end else if (launch_c) begin
            tx_valid_d = 1'b0;
        end

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end

        count_d = count_q + CW'(push_c) - CW'(pop_c);
        ready_d = (count_d != CW'(FIFO_DEPTH));
    end

    assign phase      = phase_q;
    assign fifo_count = count_q;
    assign in_ready   = ready_q;
    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign tx_tag     = tx_tag_q;

endmodule

// File: tb/tb_cdc_tx_3g2g.sv
// Bench for cdc_tx_3g2g: queue-based frame model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_cdc_tx_3g2g;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_tag;
    logic [1:0]    phase;
    logic [2:0]    fifo_count;

    always #5 clk = ~clk;

    cdc_tx_3g2g #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk_3g     (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_tag     (tx_tag),
        .phase      (phase),
        .fifo_count (fifo_count)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: cycle index since reset, a word queue and the launch register.
    logic [DW-1:0] mq[$];
    int            m_n;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_tag;
    logic          m_acc;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic model_step(input logic v, input logic [DW-1:0] d, input logic r);
        int pre_size;
        m_acc = 1'b0;
        if (r) begin
            mq.delete();
            m_n     = 0;
            m_data  = '0;
            m_valid = 1'b0;
            m_tag   = 1'b0;
        end else begin
            pre_size = mq.size();
            m_acc    = v && (pre_size < int'(DEPTH));
            if ((m_n % 3) != 2) begin
                if (pre_size > 0) begin
                    m_data  = mq.pop_front();
                    m_valid = 1'b1;
                    m_tag   = ~m_tag;
                end else begin
                    m_valid = 1'b0;
                end
            end
            if (m_acc) mq.push_back(d);
            m_n++;
        end
    endtask

    task automatic compare_model();
        chk("phase",      int'(phase),      m_n % 3);
        chk("fifo_count", int'(fifo_count), mq.size());
        chk("in_ready",   int'(in_ready),   (mq.size() != int'(DEPTH)) ? 1 : 0);
        chk("tx_valid",   int'(tx_valid),   int'(m_valid));
        chk("tx_tag",     int'(tx_tag),     int'(m_tag));
        chk("tx_data",    int'(tx_data),    int'(m_data));
    endtask

    // Entered at a falling edge: check the current cycle, drive, advance the model.
    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic r);
        compare_model();
        rst      = r;
        in_valid = v;
        in_data  = d;
        model_step(v, d, r);
        @(negedge clk);
    endtask

    task automatic do_reset();
        repeat (3) cyc(1'b0, '0, 1'b1);
    endtask

    logic [DW-1:0] pin[$];
    logic [DW-1:0] pout[$];
    int            first_low;
    int            toggles;
    logic          prev_tag;
    logic [DW-1:0] wd;
    logic          wv;
    int            guard;

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        model_step(1'b0, '0, 1'b1);
        @(negedge clk);

        // Reset values and free-running phase with no input
        do_reset();
        chk("rst_phase", int'(phase), 0);
        chk("rst_count", int'(fifo_count), 0);
        chk("rst_ready", int'(in_ready), 1);
        chk("rst_txd",   int'(tx_data), 0);
        chk("rst_txv",   int'(tx_valid), 0);
        chk("rst_tag",   int'(tx_tag), 0);
        for (int i = 0; i < 6; i++) begin
            chk("idle_phase", int'(phase), i % 3);
            chk("idle_txv",   int'(tx_valid), 0);
            cyc(1'b0, '0, 1'b0);
        end

        // Single word: 0xA5 accepted in cycle 0 launches at edge B
        do_reset();
        cyc(1'b1, 8'hA5, 1'b0);
        cyc(1'b0, '0, 1'b0);
        chk("sw_c2_v", int'(tx_valid), 1);
        chk("sw_c2_d", int'(tx_data), 8'hA5);
        cyc(1'b0, '0, 1'b0);
        chk("sw_c3_v", int'(tx_valid), 1);
        chk("sw_c3_d", int'(tx_data), 8'hA5);
        chk("sw_c3_t", int'(tx_tag), 1);
        cyc(1'b0, '0, 1'b0);
        chk("sw_c4_v", int'(tx_valid), 0);
        chk("sw_c4_d", int'(tx_data), 8'hA5);
        repeat (3) cyc(1'b0, '0, 1'b0);

        // Push into empty FIFO on edge A is not popped on that edge
        do_reset();
        repeat (3) cyc(1'b0, '0, 1'b0);
        cyc(1'b1, 8'h3C, 1'b0);
        chk("le_c4_cnt", int'(fifo_count), 1);
        cyc(1'b0, '0, 1'b0);
        chk("le_c5_v", int'(tx_valid), 1);
        chk("le_c5_d", int'(tx_data), 8'h3C);
        cyc(1'b0, '0, 1'b0);
        chk("le_c6_v", int'(tx_valid), 1);
        chk("le_c6_d", int'(tx_data), 8'h3C);
        repeat (3) cyc(1'b0, '0, 1'b0);

        // Full-rate burst: in_ready first low in cycle 9, then one cycle in three
        do_reset();
        first_low = -1;
        wd = 8'h00;
        for (int i = 0; i < 30; i++) begin
            if (!in_ready && first_low < 0) first_low = i;
            if (i >= 9) chk("burst_ready", int'(in_ready), ((i - 9) % 3 != 0) ? 1 : 0);
            cyc(1'b1, wd, 1'b0);
            if (m_acc) wd = wd + 8'd1;
        end
        chk("burst_first_low", first_low, 9);

        // Mid-operation reset in a phase-1 cycle with a full buffer behind it
        do_reset();
        for (int i = 0; i < 10; i++) cyc(1'b1, 8'h80 + DW'(i), 1'b0);
        chk("mr_phase1", int'(phase), 1);
        chk("mr_full", int'(fifo_count) >= 3 ? 1 : 0, 1);
        cyc(1'b1, 8'h8F, 1'b1);
        chk("mr_cnt",   int'(fifo_count), 0);
        chk("mr_txv",   int'(tx_valid), 0);
        chk("mr_txd",   int'(tx_data), 0);
        chk("mr_phase", int'(phase), 0);
        for (int i = 0; i < 12; i++) begin
            chk("mr_no_old", int'(tx_valid) + int'(tx_data), 0);
            cyc(1'b0, '0, 1'b0);
        end

        // Wrap-around: 20 words with random in_valid, order and tag toggles
        do_reset();
        pin.delete();
        pout.delete();
        toggles  = 0;
        prev_tag = tx_tag;
        guard    = 0;
        while ((pin.size() < 20 || guard < 400) && guard < 400) begin
            if (tx_valid && phase != 2'd0) pout.push_back(tx_data);
            if (tx_tag != prev_tag) toggles++;
            prev_tag = tx_tag;
            wv = (pin.size() < 20) ? 1'($urandom_range(0, 1)) : 1'b0;
            wd = 8'($urandom);
            cyc(wv, wd, 1'b0);
            if (m_acc) pin.push_back(wd);
            guard++;
            if (pin.size() == 20 && mq.size() == 0 && guard < 390) guard = 390;
        end
        chk("wrap_count", pout.size(), 20);
        chk("wrap_toggles", toggles, 20);
        for (int i = 0; i < 20; i++) begin
            if (i < pout.size()) chk("wrap_order", int'(pout[i]), int'(pin[i]));
        end

        // Long random run including occasional resets
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 63) == 0));
        end
        compare_model();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
